// File: rtl/ov5640_pkg.sv
// Shared types for the OV5640 configuration scheduler
// and the baked camera init image.
package ov5640_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROM_RD,
    ST_ISSUE,
    ST_WAIT,
    ST_DELAY
  } state_t;

  typedef struct packed {
    logic [7:0]  data;
    logic [15:0] addr;
  } entry_t;

  localparam logic [15:0] DELAY_ADDR = 16'hFFFF;

  // Image generated from the camera .mif; slots past the
  // table are zero-length delays so they issue nothing.
  function automatic entry_t rom_word(input int unsigned i);
    entry_t e;
    case (i)
      0: e = '{data: 8'h82, addr: 16'h3008};
      1: e = '{data: 8'h01, addr: DELAY_ADDR};
      2: e = '{data: 8'h02, addr: 16'h3008};
      default: e = '{data: 8'h00, addr: DELAY_ADDR};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/ov5640_init_rom.sv
// Synchronous init-table ROM, one cycle read latency.
// Contents come from the image held in ov5640_pkg.
module ov5640_init_rom
  import ov5640_pkg::*;
#(
  parameter int INIT_LEN = 256,
  parameter int IW       = 8
) (
  input  logic          clk_sys,
  input  logic [IW-1:0] idx,
  output entry_t        rd_q
);

  entry_t rd_d;

  always_comb begin
    rd_d = rom_word(32'(idx));
    if (32'(idx) >= 32'(INIT_LEN)) begin
      rd_d = '{data: 8'h00, addr: DELAY_ADDR};
    end
  end

  always_ff @(posedge clk_sys) begin
    rd_q <= rd_d;
  end

endmodule

// File: rtl/ov5640_cfg_sched.sv
// Merges the boot init table and HPS register writes
// into broadcast SCCB writes for the two cameras.
module ov5640_cfg_sched
  import ov5640_pkg::*;
#(
  parameter int          INIT_LEN   = 256,
  parameter int          CYC_PER_MS = 50000,
  parameter logic [15:0] DELAY_ADDR =
    ov5640_pkg::DELAY_ADDR
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        init_start,
  input  logic [1:0]  cam_mask,
  input  logic        hps_valid,
  input  logic [15:0] hps_addr,
  input  logic [7:0]  hps_data,
  output logic        hps_ready,
  output logic [1:0]  sccb_start,
  output logic [15:0] sccb_addr,
  output logic [7:0]  sccb_data,
  input  logic [1:0]  sccb_busy,
  input  logic [1:0]  sccb_nack,
  output logic        init_busy,
  output logic        init_done,
  output logic [7:0]  nack_cnt
);

  localparam int IW =
    (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1;
  localparam logic [IW-1:0] LAST =
    IW'(INIT_LEN - 1);

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          init_busy_q, init_busy_d;
  logic          init_done_q, init_done_d;
  logic          restart_q, restart_d;
  logic          op_init_q, op_init_d;
  logic [1:0]    mask_q, mask_d;
  logic          first_q, first_d;
  logic [31:0]   cnt_q, cnt_d;
  logic          hold_vld_q, hold_vld_d;
  entry_t        hold_q, hold_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    nack_q, nack_d;
  logic          entry_done;
  entry_t        rom_rd;

  ov5640_init_rom #(
    .INIT_LEN (INIT_LEN),
    .IW       (IW)
  ) u_rom (
    .clk_sys (clk_sys),
    .idx     (idx_q),
    .rd_q    (rom_rd)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // An idle-cycle init_start is held off one cycle so the
  // ROM sees the rewound index before ROM_RD.
  always_comb begin
    state_d    = state_q;
    entry_done = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (init_start) begin
          state_d = ST_IDLE;
        end else if (init_busy_q) begin
          state_d = ST_ROM_RD;
        end else if (hold_vld_q) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ROM_RD: begin
        if (rom_rd.addr != DELAY_ADDR) begin
          state_d = ST_ISSUE;
        end else if (rom_rd.data == 8'd0) begin
          entry_done = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_DELAY;
        end
      end
      ST_ISSUE: begin
        if (cam_mask == 2'b00) begin
          entry_done = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!first_q &&
            ((sccb_busy & mask_q) == 2'b00)) begin
          entry_done = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_DELAY: begin
        if (cnt_q == 32'd0) begin
          entry_done = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    idx_d       = idx_q;
    init_busy_d = init_busy_q;
    init_done_d = init_done_q;
    restart_d   = restart_q;
    op_init_d   = op_init_q;
    mask_d      = mask_q;
    first_d     = first_q;
    cnt_d       = cnt_q;
    hold_vld_d  = hold_vld_q;
    hold_d      = hold_q;
    addr_d      = addr_q;
    data_d      = data_q;
    nack_d      = nack_q;

    if (state_q == ST_IDLE && state_d == ST_ROM_RD) begin
      op_init_d = 1'b1;
    end
    if (state_q == ST_IDLE && state_d == ST_ISSUE) begin
      op_init_d = 1'b0;
      addr_d    = hold_q.addr;
      data_d    = hold_q.data;
    end
    if (state_q == ST_ROM_RD) begin
      if (rom_rd.addr != DELAY_ADDR) begin
        addr_d = rom_rd.addr;
        data_d = rom_rd.data;
      end
      cnt_d = 32'(rom_rd.data) * 32'(CYC_PER_MS)
            - 32'd1;
    end
    if (state_q == ST_DELAY && cnt_q != 32'd0) begin
      cnt_d = cnt_q - 32'd1;
    end
    if (state_q == ST_ISSUE) begin
      mask_d  = cam_mask;
      first_d = 1'b1;
    end
    if (state_q == ST_WAIT) begin
      first_d = 1'b0;
    end

    if (entry_done && op_init_q) begin
      if (restart_q) begin
        idx_d     = '0;
        restart_d = 1'b0;
      end else if (idx_q == LAST) begin
        init_busy_d = 1'b0;
        init_done_d = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
    if (entry_done && !op_init_q) begin
      hold_vld_d = 1'b0;
    end

    // Never abort an in-flight init entry; rewind after it.
    if (init_start) begin
      init_busy_d = 1'b1;
      init_done_d = 1'b0;
      if (state_q != ST_IDLE && op_init_q &&
          !entry_done) begin
        restart_d = 1'b1;
      end else begin
        idx_d     = '0;
        restart_d = 1'b0;
      end
    end

    if (hps_valid && !hold_vld_q) begin
      hold_vld_d = 1'b1;
      hold_d     = '{data: hps_data, addr: hps_addr};
    end

    if ((sccb_nack != 2'b00) && (nack_q != 8'hFF)) begin
      nack_d = nack_q + 8'd1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      idx_q       <= '0;
      init_busy_q <= 1'b0;
      init_done_q <= 1'b0;
      restart_q   <= 1'b0;
      op_init_q   <= 1'b0;
      mask_q      <= 2'b00;
      first_q     <= 1'b0;
      cnt_q       <= 32'd0;
      hold_vld_q  <= 1'b0;
      hold_q      <= '0;
      addr_q      <= 16'd0;
      data_q      <= 8'd0;
      nack_q      <= 8'd0;
    end else begin
      idx_q       <= idx_d;
      init_busy_q <= init_busy_d;
      init_done_q <= init_done_d;
      restart_q   <= restart_d;
      op_init_q   <= op_init_d;
      mask_q      <= mask_d;
      first_q     <= first_d;
      cnt_q       <= cnt_d;
      hold_vld_q  <= hold_vld_d;
      hold_q      <= hold_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      nack_q      <= nack_d;
    end
  end

  always_comb begin
    sccb_start = 2'b00;
    if (state_q == ST_ISSUE && !reset) begin
      sccb_start = cam_mask;
    end
    hps_ready = (state_q == ST_IDLE) && !init_busy_q &&
                !hold_vld_q && !hps_valid && !reset;
  end

  assign sccb_addr = addr_q;
  assign sccb_data = data_q;
  assign init_busy = init_busy_q;
  assign init_done = init_done_q;
  assign nack_cnt  = nack_q;

endmodule

// File: tb/tb_ov5640_cfg_sched.sv
// Scoreboard bench for ov5640_cfg_sched with a
// behavioural busy/NACK model of the two SCCB masters.
`timescale 1ns/1ps
module tb_ov5640_cfg_sched;

  localparam int INIT_LEN = 3;
  localparam int CPM      = 20;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        init_start = 1'b0;
  logic [1:0]  cam_mask = 2'b00;
  logic        hps_valid = 1'b0;
  logic [15:0] hps_addr = 16'd0;
  logic [7:0]  hps_data = 8'd0;
  logic        hps_ready;
  logic [1:0]  sccb_start;
  logic [15:0] sccb_addr;
  logic [7:0]  sccb_data;
  logic [1:0]  sccb_busy;
  logic [1:0]  sccb_nack = 2'b00;
  logic        init_busy;
  logic        init_done;
  logic [7:0]  nack_cnt;

  typedef struct {
    logic [1:0]  mask;
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t exp_q [$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int starts = 0;
  int last_start = 0;
  int prev_start = 0;
  int blen [2] = '{10, 10};
  int bcnt [2] = '{0, 0};

  ov5640_cfg_sched #(
    .INIT_LEN   (INIT_LEN),
    .CYC_PER_MS (CPM),
    .DELAY_ADDR (16'hFFFF)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .init_start (init_start),
    .cam_mask   (cam_mask),
    .hps_valid  (hps_valid),
    .hps_addr   (hps_addr),
    .hps_data   (hps_data),
    .hps_ready  (hps_ready),
    .sccb_start (sccb_start),
    .sccb_addr  (sccb_addr),
    .sccb_data  (sccb_data),
    .sccb_busy  (sccb_busy),
    .sccb_nack  (sccb_nack),
    .init_busy  (init_busy),
    .init_done  (init_done),
    .nack_cnt   (nack_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(posedge clk_sys) begin
    for (int n = 0; n < 2; n++) begin
      if (reset) bcnt[n] <= 0;
      else if (sccb_start[n]) bcnt[n] <= blen[n];
      else if (bcnt[n] > 0) bcnt[n] <= bcnt[n] - 1;
    end
  end

  assign sccb_busy = {bcnt[1] > 0, bcnt[0] > 0};

  always @(negedge clk_sys) begin
    exp_t e;
    if (!reset && sccb_start != 2'b00) begin
      starts++;
      prev_start = last_start;
      last_start = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected start=%b addr=%h data=%h",
                 sccb_start, sccb_addr, sccb_data);
      end else begin
        e = exp_q.pop_front();
        if (sccb_start !== e.mask || sccb_addr !== e.addr ||
            sccb_data !== e.data) begin
          failures++;
          $display("FAIL sb_write got %b/%h/%h exp %b/%h/%h",
                   sccb_start, sccb_addr, sccb_data,
                   e.mask, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic wait_start(input string name,
                            input int target,
                            input int bound);
    int k = 0;
    while (starts < target && k < bound) begin
      tick();
      k++;
    end
    check(name, 32'(starts >= target), 32'd1);
  endtask

  task automatic wait_done(input string name,
                           input int bound);
    int k = 0;
    while (init_done !== 1'b1 && k < bound) begin
      tick();
      k++;
    end
    check(name, 32'(init_done), 32'd1);
  endtask

  task automatic wait_ready(input string name,
                            input int bound);
    int k = 0;
    while (hps_ready !== 1'b1 && k < bound) begin
      tick();
      k++;
    end
    check(name, 32'(hps_ready), 32'd1);
  endtask

  task automatic push(input logic [1:0] m,
                      input logic [15:0] a,
                      input logic [7:0] d);
    exp_t e;
    e.mask = m;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_init(input logic [1:0] m);
    push(m, 16'h3008, 8'h82);
    push(m, 16'h3008, 8'h02);
  endtask

  task automatic pulse_init(output int t0);
    init_start = 1'b1;
    t0 = cyc;
    tick();
    init_start = 1'b0;
  endtask

  initial begin
    int t0, h, r, s0, d;
    bit rdy_seen;

    tick();
    @(negedge clk_sys);
    check("rst_hps_ready", 32'(hps_ready), 32'd0);
    check("rst_start", 32'(sccb_start), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("rst_addr", 32'(sccb_addr), 32'd0);
    check("rst_data", 32'(sccb_data), 32'd0);
    check("rst_init_busy", 32'(init_busy), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_nack", 32'(nack_cnt), 32'd0);
    check("idle_ready", 32'(hps_ready), 32'd1);

    cam_mask = 2'b11;
    push_init(2'b11);
    pulse_init(t0);
    wait_start("init_first", 1, 20);
    check("init_lat", 32'(last_start - t0), 32'd3);
    check("init_busy_on", 32'(init_busy), 32'd1);
    check("init_ready_low", 32'(hps_ready), 32'd0);
    wait_start("init_second", 2, 200);
    check("init_not_done", 32'(init_done), 32'd0);
    check("init_gap",
          32'(last_start - prev_start >= CPM + 10), 32'd1);
    wait_done("init_done", 100);
    check("init_busy_off", 32'(init_busy), 32'd0);

    cam_mask = 2'b01;
    wait_ready("hps_ready_pre", 20);
    s0 = starts;
    hps_addr = 16'h4300;
    hps_data = 8'h30;
    push(2'b01, 16'h4300, 8'h30);
    hps_valid = 1'b1;
    h = cyc;
    tick();
    hps_valid = 1'b0;
    check("hps_ready_hold", 32'(hps_ready), 32'd0);
    wait_start("hps_start", s0 + 1, 10);
    check("hps_lat", 32'(last_start - h), 32'd2);
    tick(4);
    check("hps_ready_busy", 32'(hps_ready), 32'd0);
    wait_ready("hps_ready_back", 50);
    r = cyc;
    check("hps_ready_after_fall",
          32'(r >= h + 13), 32'd1);
    check("hold_addr", 32'(sccb_addr), 32'h4300);
    check("hold_data", 32'(sccb_data), 32'h30);

    blen[0] = 5;
    blen[1] = 40;
    cam_mask = 2'b11;
    s0 = starts;
    push_init(2'b11);
    pulse_init(t0);
    wait_start("uneq_first", s0 + 1, 20);
    wait_start("uneq_second", s0 + 2, 300);
    check("uneq_gap",
          32'(last_start - prev_start >= 41 + CPM), 32'd1);
    wait_done("uneq_done", 100);

    blen[0] = 10;
    blen[1] = 10;
    s0 = starts;
    push_init(2'b11);
    push(2'b11, 16'h5000, 8'h11);
    pulse_init(t0);
    tick(4);
    hps_addr = 16'h5000;
    hps_data = 8'h11;
    hps_valid = 1'b1;
    tick();
    hps_valid = 1'b0;
    rdy_seen = 1'b0;
    for (int k = 0; k < 300 && init_done !== 1'b1; k++) begin
      if (hps_ready) rdy_seen = 1'b1;
      tick();
    end
    d = cyc;
    check("mix_done", 32'(init_done), 32'd1);
    check("mix_ready_low", 32'(rdy_seen), 32'd0);
    check("mix_pre_hps", 32'(starts - s0), 32'd2);
    wait_start("mix_hps", s0 + 3, 20);
    check("mix_hps_after", 32'(last_start >= d), 32'd1);
    wait_ready("mix_ready_back", 50);

    cam_mask = 2'b00;
    s0 = starts;
    pulse_init(t0);
    wait_done("zmask_done", 3 * INIT_LEN + CPM + 30);
    d = cyc;
    check("zmask_no_start", 32'(starts - s0), 32'd0);
    check("zmask_delay", 32'(d - t0 >= CPM), 32'd1);

    cam_mask = 2'b11;
    s0 = starts;
    push_init(2'b11);
    pulse_init(t0);
    wait_start("rst_run_first", s0 + 1, 20);
    sccb_nack = 2'b01;
    tick(3);
    sccb_nack = 2'b00;
    tick();
    check("nack_cnt", 32'(nack_cnt), 32'd3);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk_sys);
    check("rst_mid_start", 32'(sccb_start), 32'd0);
    tick();
    check("rst_mid_nack", 32'(nack_cnt), 32'd0);
    check("rst_mid_busy", 32'(init_busy), 32'd0);
    check("rst_mid_done", 32'(init_done), 32'd0);
    check("rst_mid_addr", 32'(sccb_addr), 32'd0);
    reset = 1'b0;
    tick(2);
    s0 = starts;
    push_init(2'b11);
    pulse_init(t0);
    wait_start("rerun_first", s0 + 1, 20);
    check("rerun_lat", 32'(last_start - t0), 32'd3);
    wait_done("rerun_done", 200);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
